// File: rtl/ifu_fetch_stage.sv
// rtl/ifu_fetch_stage.sv - instruction fetch stage with one outstanding imem request
// Redirects always win: they retarget pc and squash any in-flight or held instruction.
module ifu_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic [63:0] if_snpc,
  output logic [63:0] fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic        drop;
  logic        handshake;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (!redirect_valid && imem_gnt) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_nxt = (redirect_valid || drop) ? S_REQ : S_HOLD;
      S_HOLD:  if (redirect_valid || out_ready) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    if (!rst) begin
      imem_req = (state == S_REQ) && !redirect_valid;
      if_valid = (state == S_HOLD) && !redirect_valid;
    end
    handshake = if_valid && out_ready;
  end

  assign imem_addr = pc;
  assign if_snpc   = if_pc + 64'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      drop        <= 1'b0;
      if_inst     <= 32'd0;
      if_pc       <= 64'd0;
      fetch_count <= 64'd0;
    end else begin
      // A redirect retargets pc in every state; the rest only matters without one.
      if (redirect_valid) pc <= redirect_pc;
      case (state)
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!redirect_valid && !drop) begin
              if_inst <= imem_rdata;
              if_pc   <= pc;
            end
            drop <= 1'b0;
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            pc          <= pc + 64'd4;
            fetch_count <= fetch_count + 64'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ifu_fetch_stage.md
IFU_FETCH_STAGE -- requirements
Module: ifu_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h80000000: address of the first fetch after reset.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 out_ready  input  1  decode stage can accept an instruction this cycle.
REQ-005 redirect_valid  input  1  control-flow redirect request from a later stage.
REQ-006 redirect_pc  input  64  target PC for the redirect.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  64  request address; equals current fetch PC.
REQ-009 imem_gnt  input  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 if_valid  output  1  fetched instruction presented to decode.
REQ-013 if_inst  output  32  instruction word.
REQ-014 if_pc  output  64  PC of if_inst.
REQ-015 if_snpc  output  64  if_pc + 4.
REQ-016 fetch_count  output  64  count of instructions handed to decode.

Function
REQ-017 FSM states SHALL be S_REQ, S_WAIT and S_HOLD, with at most one memory request outstanding.
REQ-018 In S_REQ: imem_req = !redirect_valid, imem_addr = pc; on imem_req && imem_gnt -> S_WAIT; otherwise the block stays in S_REQ.
REQ-019 In S_WAIT: imem_req = 0; on imem_rvalid with drop = 0, latch imem_rdata into if_inst and pc into if_pc, then -> S_HOLD.
REQ-020 In S_WAIT: on imem_rvalid with drop = 1, discard the data, clear drop, then -> S_REQ.
REQ-021 In S_HOLD: if_valid = !redirect_valid (combinational mask); handshake occurs when if_valid && out_ready.
REQ-022 On a S_HOLD handshake: pc <= pc + 4 (64-bit, modulo 2^64, wraps silently), fetch_count increments by 1, -> S_REQ.
REQ-023 In S_HOLD with no handshake: if_inst and if_pc SHALL hold stable and the block stays in S_HOLD.
REQ-024 Redirect in S_REQ: pc <= redirect_pc, no request is issued that cycle, stay in S_REQ; imem_gnt is ignored.
REQ-025 Redirect in S_WAIT: pc <= redirect_pc, drop <= 1, stay in S_WAIT until imem_rvalid.
REQ-026 Redirect in S_WAIT in the same cycle as imem_rvalid: discard the data, pc <= redirect_pc, drop <= 0, -> S_REQ.
REQ-027 Redirect in S_HOLD: no handshake occurs (even if out_ready = 1), fetch_count is unchanged, the held instruction is discarded, pc <= redirect_pc, -> S_REQ.
REQ-028 Successive redirects SHALL apply last-wins: pc always reflects the most recent redirect_pc.
REQ-029 if_valid SHALL be 0 in S_REQ and S_WAIT.
REQ-030 if_snpc SHALL be combinational if_pc + 4.
REQ-031 Best-case latency: request cycle N, gnt at N, rvalid at N+1, if_valid at N+2; sustained throughput is one instruction per 3 cycles.
REQ-032 imem_rvalid in S_REQ or S_HOLD SHALL be ignored and SHALL NOT change state.
REQ-033 An imem_addr with nonzero bits [1:0] SHALL still be issued unchanged; alignment checking belongs to later stages.

Reset
REQ-034 While rst = 1: state = S_REQ, pc = RESET_PC, drop = 0, if_inst = 0, if_pc = 0, fetch_count = 0.
REQ-035 While rst = 1, imem_req = 0 and if_valid = 0; redirect_valid is ignored.
REQ-036 The first request SHALL issue in the first cycle after rst deasserts.
REQ-037 Reset asserted mid-transaction (S_WAIT or S_HOLD) SHALL abandon the transaction.
REQ-038 A late imem_rvalid arriving after reset SHALL be ignored per REQ-032.

Verification
REQ-039 Reset release, gnt immediate, rvalid next cycle with rdata 32'h00000413, out_ready = 1 -> imem_addr 80000000; if_valid with if_pc 80000000, if_inst 00000413, if_snpc 80000004; next imem_addr 80000004; fetch_count 1.
REQ-040 out_ready = 0 for 5 cycles in S_HOLD -> if_inst and if_pc stable for 5 cycles and no new imem_req; on out_ready = 1, fetch_count +1 and imem_addr advances by 4.
REQ-041 Redirect to 80000100 while in S_WAIT, then rvalid 2 cycles later -> data discarded, if_valid never asserts for the old PC, next imem_addr 80000100.
REQ-042 Redirect to 80000200 in S_HOLD with out_ready = 1 -> if_valid = 0 that cycle, fetch_count unchanged, next request address 80000200.
REQ-043 pc = FFFFFFFFFFFFFFFC, handshake -> next imem_addr 0000000000000000; rst asserted in S_WAIT -> next cycle imem_addr 80000000, late rvalid ignored.
REQ-044 Random gnt/rvalid delays (0-7 cycles) with random redirects -> if_pc sequence matches a reference model, no duplicated or skipped PC, and at most one request outstanding.
